multdiv_iter: RTL and testbench

- Iterative signed 32-bit multiply/divide unit in the processor's execute stage.
- Feeds the pipeline's data_result_mult_div, data_exception_multdiv and ready signals.
- The pipeline stalls on the busy output and writes back data_result when data_resultRDY pulses.
- Uses a multi-cycle FSM so the combinational multiplier/divider does not set the clock period.

---
 rtl/multdiv_iter.sv | 190 +++++++++++++++++++
 tb/tb_multdiv_iter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: radix-2 Booth (radix-4 with MULTDIV_RADIX4_EN)
// and restoring division on magnitudes, one step per clock.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULTDIV_RADIX4_EN
    localparam int MSTEPS = WIDTH / 2;
`else
    localparam int MSTEPS = WIDTH;
`endif
    localparam logic [CW-1:0] MLAST = CW'(MSTEPS);
    localparam logic [CW-1:0] DLAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [PW-1:0]    booth_nxt;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

`ifdef MULTDIV_RADIX4_EN
    logic [WIDTH+1:0] a4, m1, m2, s4;

    // Accumulator widened by two bits so +/-2M never overflows before the shift
    always_comb begin
        a4 = {{2{prod_q[PW-1]}}, prod_q[PW-1:WIDTH+1]};
        m1 = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        m2 = {mcand_q[WIDTH-1], mcand_q, 1'b0};
        unique case (prod_q[2:0])
            3'b001, 3'b010: s4 = a4 + m1;
            3'b011:         s4 = a4 + m2;
            3'b100:         s4 = a4 - m2;
            3'b101, 3'b110: s4 = a4 - m1;
            default:        s4 = a4;
        endcase
        booth_nxt = {s4, prod_q[WIDTH:2]};
    end
`else
    logic [WIDTH:0] a2, m2, s2;

    // One extra accumulator bit keeps subtracting the most-negative value exact
    always_comb begin
        a2 = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
        m2 = {mcand_q[WIDTH-1], mcand_q};
        unique case (prod_q[1:0])
            2'b01:   s2 = a2 + m2;
            2'b10:   s2 = a2 - m2;
            default: s2 = a2;
        endcase
        booth_nxt = {s2, prod_q[WIDTH:1]};
    end
`endif

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvsr_q};
        abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        res_d   = res_q;
        exc_d   = exc_q;
        if (ctrl_MULT) begin
            state_d = MUL;
            cnt_d   = '0;
            mcand_d = data_operandA;
            prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (ctrl_DIV) begin
            state_d = DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d   = (data_operandA == MINV) && (data_operandB == '1);
            dz_d    = (data_operandB == '0);
        end else begin
            unique case (state_q)
                MUL: begin
                    if (cnt_q == MLAST) begin
                        state_d = DONE;
                        res_d   = prod_q[WIDTH:1];
                        exc_d   = prod_q[PW-1:WIDTH+1] != {WIDTH{prod_q[WIDTH]}};
                    end else begin
                        prod_d = booth_nxt;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    if (dz_q) begin
                        state_d = DONE;
                        res_d   = '0;
                        exc_d   = 1'b1;
                    end else if (cnt_q == DLAST) begin
                        state_d = DONE;
                        res_d   = neg_q ? -quo_q : quo_q;
                        exc_d   = ovf_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!diff[WIDTH]) begin
                            rem_d = diff[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = trial[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: driver pushes model results, a
// negedge monitor pops and compares on every data_resultRDY.
module tb_multdiv_iter;

`ifdef MULTDIV_RADIX4_EN
    localparam int MSTEPS = 16;
`else
    localparam int MSTEPS = 32;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_seen = 0;
    logic [31:0] last_res = '0;

    multdiv_iter #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    function automatic exp_t mul_model(logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        e.res = p[31:0];
        e.exc = (p != 64'($signed(p[31:0])));
        e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t div_model(logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic signed [63:0] q;
        e.cyc = 0;
        if (b == 0) begin
            e.res = 0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q = 64'($signed(a)) / 64'($signed(b));
            e.res = q[31:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            rdy_seen++;
            if (sb.size() == 0) begin
                chk("spurious_rdy", 64'(data_resultRDY), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(data_result), 64'(e.res));
                chk("exception", 64'(data_exception), 64'(e.exc));
                chk("rdy_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_rdy", 64'(busy), 64'(1));
            end
        end
    end

    task automatic start(input bit mul, input bit both,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mul || both;
        ctrl_DIV = !mul || both;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        sb.delete();
        if (mul || both) begin
            e = mul_model(a, b);
            e.cyc = cyc + MSTEPS + 1;
        end else begin
            e = div_model(a, b);
            e.cyc = cyc + ((b == 0) ? 1 : 33);
        end
        last_res = e.res;
        sb.push_back(e);
    endtask

    task automatic wait_done(string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending %0d want 0", name, sb.size());
            sb.delete();
        end
        @(negedge clock);
        chk({name, "_busy_idle"}, 64'(busy), 64'(0));
        chk({name, "_rdy_idle"}, 64'(data_resultRDY), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] tbl [6];
        tbl = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
        unique case ($urandom_range(3))
            0: return tbl[$urandom_range(5)];
            1: return 32'($signed(16'($urandom)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int n;
        #500000;
        $display("FAIL global_timeout cycles %0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prev;
        int n;
        #12;
        chk("rst_result", 64'(data_result), 64'(0));
        chk("rst_exc", 64'(data_exception), 64'(0));
        chk("rst_rdy", 64'(data_resultRDY), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        start(1, 0, 32'd6, 32'd7);
        chk("busy_after_start", 64'(busy), 64'(1));
        wait_done("mul6x7");
        start(1, 0, 32'hFFFF_FFFB, 32'd3);
        wait_done("mul_neg");
        start(1, 0, 32'h0001_0000, 32'h0001_0000);
        wait_done("mul_ovf");
        start(0, 0, 32'd100, 32'hFFFF_FFF9);
        wait_done("div_neg");
        start(0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");

        prev = last_res;
        start(0, 0, 32'd123, 32'd0);
        chk("dz_hold", 64'(data_result), 64'(prev));
        wait_done("div_zero");

        start(1, 0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        start(0, 0, 32'd50, 32'd5);
        wait_done("abort");
        start(1, 1, 32'd9, 32'd3);
        wait_done("both");

        start(0, 0, 32'd1000, 32'd7);
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_result", 64'(data_result), 64'(0));
        chk("arst_exc", 64'(data_exception), 64'(0));
        chk("arst_rdy", 64'(data_resultRDY), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        n = rdy_seen;
        repeat (40) @(negedge clock);
        chk("no_rdy_after_rst", 64'(rdy_seen - n), 64'(0));
        start(1, 0, 32'd2, 32'd2);
        wait_done("mul_after_rst");

        for (int i = 0; i < 30; i++) begin
            start($urandom_range(1) == 1, 0, pick(), pick());
            wait_done("rand");
        end
        for (int i = 0; i < 6; i++) begin
            start($urandom_range(1) == 1, 0, pick(), pick());
            repeat ($urandom_range(20, 2)) @(posedge clock);
            start($urandom_range(1) == 1, 0, pick(), pick());
            wait_done("rand_abort");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
